screen_transition_painter: RTL and testbench
============================================

SCREEN_TRANSITION_PAINTER -- requirements
Module: screen_transition_painter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- COLS, 40, tile columns.
- ROWS, 30, tile rows.
- BANNER_ADDR, 576, first banner tile address (row 14, col 16).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock; all logic on posedge.
- rst, in, 1, asynchronous active-low reset.
- drawingState, in, 4, screen mode from the upstream drawing state handler (1 credentials, 2 time, 3 playing, 4 player dead).
- fb_ready, in, 1, tile frame buffer accepts a write this cycle.
- fb_we, out, 1, tile write request.
- fb_addr, out, 11, tile address, row*COLS+col.
- fb_data, out, 8, tile code (ASCII for characters).
- busy, out, 1, repaint in progress.
- done, out, 1, one-cycle pulse when a repaint completes.

Function
REQ-003 The block SHALL hold last_state, the mode of the most recent repaint; an IDLE cycle with drawingState != last_state SHALL start a repaint and latch drawingState into last_state.
REQ-004 The FSM SHALL have states IDLE, CLEAR, BANNER and FINISH.
- IDLE -> CLEAR on a mode change.
- CLEAR -> BANNER after address COLS*ROWS-1 is accepted.
- BANNER -> FINISH after the 8th banner tile is accepted.
- FINISH -> IDLE after one cycle.
REQ-005 A write SHALL complete only in a cycle where fb_we=1 and fb_ready=1; while fb_ready=0, fb_addr, fb_data and fb_we SHALL hold stable.
REQ-006 CLEAR SHALL write every address 0..COLS*ROWS-1 in ascending order with tile 0x00, using separate row and column counters; the column SHALL wrap at COLS-1 and increment the row.
REQ-007 BANNER SHALL write 8 tiles at BANNER_ADDR..BANNER_ADDR+7, with content selected by last_state:
- 1: "PASSWORD".
- 2: "SET TIME" (space = 0x20).
- 4: "GAMEOVER".
- 3 or any other value: BANNER is skipped and the FSM goes CLEAR -> FINISH.
REQ-008 With fb_ready held high, the block SHALL issue one write per cycle; the first write SHALL be in the cycle after the change is detected.
REQ-009 busy SHALL be 1 in CLEAR, BANNER and FINISH, and 0 in IDLE.
REQ-010 done SHALL pulse for exactly one cycle in FINISH.
REQ-011 A mode change detected during CLEAR or BANNER SHALL abort the repaint: last_state is relatched, the counters reset to address 0, and CLEAR restarts the next cycle. No done pulse SHALL be produced for the aborted repaint.
REQ-012 A mode change during FINISH SHALL be deferred: done still pulses, and the change is detected in IDLE the following cycle.
REQ-013 A mode that returns to last_state before being sampled SHALL cause no repaint.
REQ-014 fb_we SHALL be 0 in IDLE and FINISH.

Reset
REQ-015 While rst=0, the block SHALL asynchronously force: state=IDLE, last_state=0, counters=0, fb_we=0, fb_addr=0, fb_data=0, busy=0, done=0.
REQ-016 After reset release, any nonzero drawingState SHALL trigger a full repaint.
REQ-017 Reset asserted mid-repaint SHALL abandon the repaint immediately with no further writes.

Configuration
REQ-018 With SCREEN_BORDER_EN defined, CLEAR SHALL write tile 0x23 ('#') at every tile in row 0, row ROWS-1, col 0 and col COLS-1, and 0x00 elsewhere.
REQ-019 Without SCREEN_BORDER_EN, CLEAR SHALL write 0x00 to all tiles; all other behaviour is identical and write counts are unchanged.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then drawingState=1 with fb_ready=1 -> 1200 clears then "PASSWORD" at 576..583; busy high for 1209 cycles; done pulses once.
- drawingState 1->3 -> 1200 writes of 0x00 only, no banner writes, done 1201 cycles after the change.
- fb_ready toggled 1,0,1,0 during BANNER for mode 4 -> each tile ("G","A",...) held stable across stall cycles; exactly 8 banner writes.
- drawingState 1->2 at clear address 500 -> writes restart at address 0; "SET TIME" drawn; single done pulse.
- SCREEN_BORDER_EN defined, mode 2 -> addresses 0, 39, 40, 1199 get 0x23; address 41 gets 0x00.
- rst low at clear address 700 -> fb_we=0 with no clock edge; rst high with mode unchanged -> repaint restarts at address 0.

Source files
------------

// File: rtl/screen_transition_painter.sv
// Repaints the tile frame buffer on a screen mode change: clear, then banner.
// Define SCREEN_BORDER_EN to draw a '#' frame around the screen while clearing.
module screen_transition_painter #(
   parameter int COLS        = 40,
   parameter int ROWS        = 30,
   parameter int BANNER_ADDR = 576
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  drawingState,
   input  logic        fb_ready,
   output logic        fb_we,
   output logic [10:0] fb_addr,
   output logic [7:0]  fb_data,
   output logic        busy,
   output logic        done
);

   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

`ifdef SCREEN_BORDER_EN
   localparam logic [7:0] BORDER_TILE = 8'h23;
`else
   localparam logic [7:0] BORDER_TILE = 8'h00;
`endif

   typedef enum logic [1:0] {IDLE, CLEAR, BANNER, FINISH} state_t;

   state_t        state;
   logic [3:0]    lastState;
   logic [RW-1:0] row;
   logic [CW-1:0] col;
   logic [2:0]    bIdx;

   logic          wrapCol;
   logic          lastCell;
   logic          edgeCell;
   logic          modeChange;
   logic [RW-1:0] nRow;
   logic [CW-1:0] nCol;
   logic [7:0]    nTile;

   function automatic logic hasBanner(input logic [3:0] m);
      return (m == 4'd1) || (m == 4'd2) || (m == 4'd4);
   endfunction

   function automatic logic [7:0] bannerTile(input logic [3:0] m,
                                             input logic [2:0] i);
      logic [63:0] s;
      logic [5:0]  sh;
      case (m)
         4'd1:    s = "PASSWORD";
         4'd2:    s = "SET TIME";
         4'd4:    s = "GAMEOVER";
         default: s = '0;
      endcase
      // first character sits in the top byte
      sh = {~i, 3'b000};
      return s[sh +: 8];
   endfunction

   always_comb begin
      wrapCol    = (col == COL_LAST);
      nCol       = wrapCol ? '0 : col + 1'b1;
      nRow       = wrapCol ? row + 1'b1 : row;
      lastCell   = wrapCol && (row == ROW_LAST);
      edgeCell   = (nRow == '0) || (nRow == ROW_LAST) ||
                   (nCol == '0) || (nCol == COL_LAST);
      nTile      = edgeCell ? BORDER_TILE : 8'h00;
      modeChange = (drawingState != lastState);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         lastState <= '0;
         row       <= '0;
         col       <= '0;
         bIdx      <= '0;
         fb_we     <= 1'b0;
         fb_addr   <= '0;
         fb_data   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (modeChange && state != FINISH) begin
         // start, or abort and restart, from tile 0
         state     <= CLEAR;
         lastState <= drawingState;
         row       <= '0;
         col       <= '0;
         bIdx      <= '0;
         fb_we     <= 1'b1;
         fb_addr   <= '0;
         fb_data   <= BORDER_TILE;
         busy      <= 1'b1;
         done      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: ;
            CLEAR: begin
               if (fb_ready) begin
                  if (!lastCell) begin
                     row     <= nRow;
                     col     <= nCol;
                     fb_addr <= fb_addr + 11'd1;
                     fb_data <= nTile;
                  end else if (hasBanner(lastState)) begin
                     state   <= BANNER;
                     bIdx    <= '0;
                     fb_addr <= 11'(BANNER_ADDR);
                     fb_data <= bannerTile(lastState, 3'd0);
                  end else begin
                     state   <= FINISH;
                     fb_we   <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end
            BANNER: begin
               if (fb_ready) begin
                  if (bIdx == 3'd7) begin
                     state   <= FINISH;
                     fb_we   <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     bIdx    <= bIdx + 3'd1;
                     fb_addr <= fb_addr + 11'd1;
                     fb_data <= bannerTile(lastState, bIdx + 3'd1);
                  end
               end
            end
            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_screen_transition_painter.sv
// Randomized and directed bench for screen_transition_painter
// against a write-list reference model built from the screen rules.
module tb_screen_transition_painter;

   localparam int COLS  = 40;
   localparam int ROWS  = 30;
   localparam int TOTAL = COLS * ROWS;
   localparam int BADDR = 576;

`ifdef SCREEN_BORDER_EN
   localparam logic [7:0] BT = 8'h23;
`else
   localparam logic [7:0] BT = 8'h00;
`endif

   logic        clk;
   logic        rst;
   logic [3:0]  drawingState;
   logic        fb_ready = 1'b1;
   logic        fb_we;
   logic [10:0] fb_addr;
   logic [7:0]  fb_data;
   logic        busy;
   logic        done;

   screen_transition_painter #(
      .COLS(COLS), .ROWS(ROWS), .BANNER_ADDR(BADDR)
   ) dut (
      .clk(clk), .rst(rst), .drawingState(drawingState),
      .fb_ready(fb_ready), .fb_we(fb_we), .fb_addr(fb_addr),
      .fb_data(fb_data), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nCmp = 0;
   int nErr = 0;

   logic [18:0] got[$];
   logic [18:0] expQ[$];
   int cyc = 0, busyCnt = 0, doneCnt = 0, doneCyc = 0;
   int stallSeen = 0, stallBad = 0;
   logic        pWe = 1'b0, pRdy = 1'b1;
   logic [10:0] pAddr = '0;
   logic [7:0]  pData = '0;

   int readyMode = 0;
   int g0, b0, d0, c0, curMode;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
      nCmp++;
      if (obs !== want) begin
         nErr++;
         $display("FAIL %s: got %0h want %0h", tag, obs, want);
      end
   endtask

   // write monitor and stall-hold observer
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (fb_we && fb_ready) got.push_back({fb_addr, fb_data});
      if (busy) busyCnt <= busyCnt + 1;
      if (done) begin
         doneCnt <= doneCnt + 1;
         doneCyc <= cyc + 1;
      end
      if (pWe && !pRdy) begin
         stallSeen <= stallSeen + 1;
         if ({fb_we, fb_addr, fb_data} !== {pWe, pAddr, pData})
            stallBad <= stallBad + 1;
      end
      pWe   <= fb_we;
      pRdy  <= fb_ready;
      pAddr <= fb_addr;
      pData <= fb_data;
   end

   always @(posedge clk) begin
      #1;
      case (readyMode)
         1:       fb_ready = ($urandom % 4) != 0;
         2:       fb_ready = (got.size() >= g0 + TOTAL) ? ~fb_ready : 1'b1;
         default: fb_ready = 1'b1;
      endcase
   end

   function automatic logic [7:0] clearTile(input int a);
      int r, c;
      r = a / COLS;
      c = a % COLS;
      return (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) ? BT : 8'h00;
   endfunction

   function automatic void addRepaint(input int m, input int n);
      logic [63:0] s;
      for (int a = 0; a < n; a++) expQ.push_back({11'(a), clearTile(a)});
      if (n == TOTAL && (m == 1 || m == 2 || m == 4)) begin
         s = (m == 1) ? "PASSWORD" : (m == 2) ? "SET TIME" : "GAMEOVER";
         for (int i = 0; i < 8; i++)
            expQ.push_back({11'(BADDR + i), s[8*(7-i) +: 8]});
      end
   endfunction

   function automatic int dataAt(input int from, input int a);
      for (int i = from; i < got.size(); i++)
         if (got[i][18:8] == 11'(a)) return int'(got[i][7:0]);
      return -1;
   endfunction

   task automatic compareQ(input string tag);
      int n, idx;
      chk({tag, "_count"}, 32'(got.size() - g0), 32'(expQ.size()));
      n = (got.size() - g0 < expQ.size()) ? got.size() - g0 : expQ.size();
      if (n > 0) begin
         idx = n - 1;
         for (int i = 0; i < n; i++)
            if (got[g0+i] !== expQ[i]) begin
               idx = i;
               break;
            end
         chk({tag, "_wr"}, 32'(got[g0+idx]), 32'(expQ[idx]));
      end
   endtask

   task automatic snap();
      g0 = got.size();
      b0 = busyCnt;
      d0 = doneCnt;
   endtask

   task automatic startMode(input int m);
      @(posedge clk);
      #1;
      snap();
      drawingState = 4'(m);
      curMode = m;
      @(negedge clk);
      #1;
      c0 = cyc;
      chk("idle_we", 32'(fb_we), 0);
      @(negedge clk);
      #1;
      chk("first_we", 32'(fb_we), 1);
      chk("first_addr", 32'(fb_addr), 0);
   endtask

   task automatic waitDone(input int d);
      int n;
      n = 0;
      while (doneCnt == d && n < 6000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("done_seen", 32'(doneCnt != d), 1);
      repeat (3) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic waitAddr(input int a);
      int n;
      n = 0;
      while (!(fb_we && fb_addr == 11'(a)) && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("addr_reached", 32'(fb_we && fb_addr == 11'(a)), 1);
   endtask

   initial begin
      int m, g1, d1, n;
      rst = 1'b0;
      drawingState = 4'd0;
      curMode = 0;
      g0 = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_we", 32'(fb_we), 0);
      chk("rst_addr", 32'(fb_addr), 0);
      chk("rst_data", 32'(fb_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("idle_busy", 32'(busy), 0);

      // full repaint, password screen
      startMode(1);
      waitDone(d0);
      expQ.delete();
      addRepaint(1, TOTAL);
      compareQ("pw");
      chk("pw_busy", 32'(busyCnt - b0), 1209);
      chk("pw_done", 32'(doneCnt - d0), 1);

      // glitch back to last mode before sampling
      @(posedge clk);
      #1;
      snap();
      drawingState = 4'd5;
      #2;
      drawingState = 4'd1;
      repeat (5) @(negedge clk);
      #1;
      chk("glitch_busy", 32'(busyCnt - b0), 0);
      chk("glitch_wr", 32'(got.size() - g0), 0);

      // playing mode: clear only
      startMode(3);
      waitDone(d0);
      expQ.delete();
      addRepaint(3, TOTAL);
      compareQ("play");
      chk("play_lat", 32'(doneCyc - c0), 1201);

      // game over with stalls during banner
      readyMode = 2;
      startMode(4);
      waitDone(d0);
      readyMode = 0;
      expQ.delete();
      addRepaint(4, TOTAL);
      compareQ("go");
      chk("go_banner_n", 32'(got.size() - g0 - TOTAL), 8);
      chk("stall_seen", 32'(stallSeen > 0), 1);
      chk("stall_hold", 32'(stallBad), 0);

      // abort at clear address 500
      startMode(1);
      waitAddr(500);
      drawingState = 4'd2;
      curMode = 2;
      waitDone(d0);
      expQ.delete();
      addRepaint(1, 501);
      addRepaint(2, TOTAL);
      compareQ("abort");
      chk("abort_done", 32'(doneCnt - d0), 1);
      chk("tile_0", 32'(dataAt(g0 + 501, 0)), 32'(BT));
      chk("tile_39", 32'(dataAt(g0 + 501, 39)), 32'(BT));
      chk("tile_40", 32'(dataAt(g0 + 501, 40)), 32'(BT));
      chk("tile_1199", 32'(dataAt(g0 + 501, 1199)), 32'(BT));
      chk("tile_41", 32'(dataAt(g0 + 501, 41)), 0);

      // change during FINISH is deferred one cycle
      startMode(1);
      n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("fin_reached", 32'(done), 1);
      drawingState = 4'd4;
      curMode = 4;
      g1 = got.size();
      d1 = doneCnt;
      @(negedge clk);
      #1;
      chk("defer_busy", 32'(busy), 0);
      chk("defer_we", 32'(fb_we), 0);
      @(negedge clk);
      #1;
      chk("defer_we1", 32'(fb_we), 1);
      chk("defer_addr", 32'(fb_addr), 0);
      waitDone(d1);
      chk("defer_dones", 32'(doneCnt - d0), 2);
      g0 = g1;
      expQ.delete();
      addRepaint(4, TOTAL);
      compareQ("defer");

      // asynchronous reset mid-clear
      startMode(1);
      waitAddr(700);
      rst = 1'b0;
      #1;
      chk("arst_we", 32'(fb_we), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_addr", 32'(fb_addr), 0);
      g1 = got.size();
      repeat (4) @(negedge clk);
      #1;
      chk("arst_nowr", 32'(got.size() - g1), 0);
      snap();
      rst = 1'b1;
      waitDone(d0);
      expQ.delete();
      addRepaint(1, TOTAL);
      compareQ("rerun");

      // random modes under random backpressure
      readyMode = 1;
      for (int k = 0; k < 4; k++) begin
         do m = $urandom_range(0, 7); while (m == curMode);
         startMode(m);
         waitDone(d0);
         expQ.delete();
         addRepaint(m, TOTAL);
         compareQ("rand");
         chk("rand_done", 32'(doneCnt - d0), 1);
      end
      readyMode = 0;
      chk("stall_hold_all", 32'(stallBad), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
